// File: rtl/ysyx_24090012_axi_sram_if.sv
// AXI4 slave-port bundle for the single-beat SRAM model. The slave modport is
// the memory side and the master modport is the requester side.
interface ysyx_24090012_axi_sram_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;

   modport slave (
      input  awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arid, arlen, rready,
      output awready, wready, bvalid, bresp, bid,
             arready, rvalid, rdata, rresp, rlast, rid
   );

   modport master (
      output awvalid, awaddr, awid, awlen, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arid, arlen, rready,
      input  awready, wready, bvalid, bresp, bid,
             arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/ysyx_24090012_axi_sram.sv
// Single-beat AXI4 SRAM slave with independent read/write FSMs and fixed latency.
// Define YSYX_24090012_SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra latency cycles.
module ysyx_24090012_axi_sram #(
   parameter logic [31:0] MEM_BASE  = 32'h2000_0000,
   parameter int          MEM_WORDS = 1024,
   parameter int          RD_LAT    = 2,
   parameter int          WR_LAT    = 1
) (
   input logic                        clock,
   input logic                        reset,
   ysyx_24090012_axi_sram_if.slave    io_slave
);
   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
   localparam logic [1:0]  OKAY      = 2'd0;
   localparam logic [1:0]  SLVERR    = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3;

   function automatic logic in_range(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - MEM_BASE;
      return (addr >= MEM_BASE) && ({1'b0, off} < MEM_BYTES);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
      return AW'((addr - MEM_BASE) >> 2);
   endfunction

   // NOTE: the array has no reset; clearing every word would force flop-based storage.
   logic [31:0] mem [MEM_WORDS];

   logic [1:0]  r_state_q, r_state_d;
   logic [7:0]  r_cnt_q, r_cnt_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [3:0]  ar_id_q, ar_id_d;
   logic [7:0]  ar_len_q, ar_len_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic [1:0]  w_state_q, w_state_d;
   logic [7:0]  w_cnt_q, w_cnt_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [3:0]  aw_id_q, aw_id_d;
   logic [7:0]  aw_len_q, aw_len_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;

   logic          ar_hs, aw_hs, rd_ok, wr_ok, wr_commit;
   logic [AW-1:0] r_idx, w_idx;
   logic [31:0]   rd_word;
   logic [1:0]    rd_extra, wr_extra;

   assign ar_hs = (r_state_q == R_IDLE) && io_slave.arvalid;
   assign aw_hs = (w_state_q == W_IDLE) && io_slave.awvalid;
   assign rd_ok = in_range(ar_addr_q) && (ar_len_q == 8'd0);
   assign wr_ok = in_range(aw_addr_q) && (aw_len_q == 8'd0);
   assign r_idx = word_idx(ar_addr_q);
   assign w_idx = word_idx(aw_addr_q);

`ifdef YSYX_24090012_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d, lfsr_s1;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // A simultaneous AR and AW each consume their own LFSR step.
   always_comb begin
      lfsr_s1 = lfsr_step(lfsr_q);
      lfsr_d  = lfsr_q;
      if (ar_hs && aw_hs)     lfsr_d = lfsr_step(lfsr_s1);
      else if (ar_hs || aw_hs) lfsr_d = lfsr_s1;
   end

   assign rd_extra = lfsr_q[1:0];
   assign wr_extra = ar_hs ? lfsr_s1[1:0] : lfsr_q[1:0];

   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= 8'h5A;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign rd_extra = 2'd0;
   assign wr_extra = 2'd0;
`endif

   // The array is committed when the write response is produced, so a reset while
   // the write is still waiting leaves the target word untouched.
   assign wr_commit = !reset && (w_state_q == W_WAIT) && (w_cnt_q == 8'd0) && wr_ok;

   // Write-first: a read sampling the word being committed this cycle sees new bytes.
   always_comb begin
      rd_word = mem[r_idx];
      if (wr_commit && (w_idx == r_idx)) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) rd_word[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
   always_comb begin
      r_state_d = r_state_q;
      r_cnt_d   = r_cnt_q;
      ar_addr_d = ar_addr_q;
      ar_id_d   = ar_id_q;
      ar_len_d  = ar_len_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: if (ar_hs) begin
            ar_addr_d = io_slave.araddr;
            ar_id_d   = io_slave.arid;
            ar_len_d  = io_slave.arlen;
            r_cnt_d   = 8'(RD_LAT - 1) + {6'd0, rd_extra};
            r_state_d = R_WAIT;
         end
         R_WAIT: if (r_cnt_q == 8'd0) begin
            r_state_d = R_RESP;
            rdata_d   = rd_ok ? rd_word : 32'd0;
            rresp_d   = rd_ok ? OKAY : SLVERR;
         end else begin
            r_cnt_d = r_cnt_q - 8'd1;
         end
         R_RESP: if (io_slave.rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      w_cnt_d   = w_cnt_q;
      aw_addr_d = aw_addr_q;
      aw_id_d   = aw_id_q;
      aw_len_d  = aw_len_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: if (aw_hs) begin
            aw_addr_d = io_slave.awaddr;
            aw_id_d   = io_slave.awid;
            aw_len_d  = io_slave.awlen;
            w_cnt_d   = 8'(WR_LAT - 1) + {6'd0, wr_extra};
            w_state_d = W_DATA;
         end
         W_DATA: if (io_slave.wvalid) begin
            wdata_d   = io_slave.wdata;
            wstrb_d   = io_slave.wstrb;
            w_state_d = W_WAIT;
         end
         W_WAIT: if (w_cnt_q == 8'd0) begin
            w_state_d = W_RESP;
            bresp_d   = wr_ok ? OKAY : SLVERR;
         end else begin
            w_cnt_d = w_cnt_q - 8'd1;
         end
         default: if (io_slave.bready) w_state_d = W_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= '0;
         ar_addr_q <= '0;
         ar_id_q   <= '0;
         ar_len_q  <= '0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
         w_state_q <= W_IDLE;
         w_cnt_q   <= '0;
         aw_addr_q <= '0;
         aw_id_q   <= '0;
         aw_len_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= OKAY;
      end else begin
         r_state_q <= r_state_d;
         r_cnt_q   <= r_cnt_d;
         ar_addr_q <= ar_addr_d;
         ar_id_q   <= ar_id_d;
         ar_len_q  <= ar_len_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         w_state_q <= w_state_d;
         w_cnt_q   <= w_cnt_d;
         aw_addr_q <= aw_addr_d;
         aw_id_q   <= aw_id_d;
         aw_len_q  <= aw_len_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   // Handshake outputs are forced to their idle values while reset is held.
   assign io_slave.arready = reset || (r_state_q == R_IDLE);
   assign io_slave.rvalid  = !reset && (r_state_q == R_RESP);
   assign io_slave.rlast   = io_slave.rvalid;
   assign io_slave.rdata   = rdata_q;
   assign io_slave.rresp   = rresp_q;
   assign io_slave.rid     = ar_id_q;
   assign io_slave.awready = reset || (w_state_q == W_IDLE);
   assign io_slave.wready  = !reset && (w_state_q == W_DATA);
   assign io_slave.bvalid  = !reset && (w_state_q == W_RESP);
   assign io_slave.bresp   = bresp_q;
   assign io_slave.bid     = aw_id_q;
endmodule

// File: tb/tb_ysyx_24090012_axi_sram.sv
// Directed self-checking bench for ysyx_24090012_axi_sram in its default
// (fixed-latency) build: RD_LAT=2, WR_LAT=1, 1024 words at 0x2000_0000.
module tb_ysyx_24090012_axi_sram;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   ysyx_24090012_axi_sram_if io_slave();

   ysyx_24090012_axi_sram #(
      .MEM_BASE (32'h2000_0000),
      .MEM_WORDS(1024),
      .RD_LAT   (RD_LAT),
      .WR_LAT   (WR_LAT)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .io_slave(io_slave)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id,
                            input logic [7:0] len, output logic [1:0] bresp,
                            output logic [3:0] bid, output int lat);
      int guard;
      io_slave.awaddr = addr; io_slave.awid = id; io_slave.awlen = len;
      io_slave.awvalid = 1'b1;
      guard = 0;
      while (!io_slave.awready && guard < 50) begin tick(); guard++; end
      tick();
      io_slave.awvalid = 1'b0;
      io_slave.wdata = data; io_slave.wstrb = strb; io_slave.wvalid = 1'b1;
      guard = 0;
      while (!io_slave.wready && guard < 50) begin tick(); guard++; end
      tick();
      io_slave.wvalid = 1'b0;
      lat = 0;
      while (!io_slave.bvalid && lat < 50) begin tick(); lat++; end
      bresp = io_slave.bresp; bid = io_slave.bid;
      io_slave.bready = 1'b1;
      tick();
      io_slave.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, output logic [31:0] rdata,
                           output logic [1:0] rresp, output logic [3:0] rid,
                           output logic rlast, output int lat);
      int guard;
      io_slave.araddr = addr; io_slave.arid = id; io_slave.arlen = len;
      io_slave.arvalid = 1'b1;
      guard = 0;
      while (!io_slave.arready && guard < 50) begin tick(); guard++; end
      tick();
      io_slave.arvalid = 1'b0;
      lat = 0;
      while (!io_slave.rvalid && lat < 50) begin tick(); lat++; end
      rdata = io_slave.rdata; rresp = io_slave.rresp;
      rid = io_slave.rid; rlast = io_slave.rlast;
      io_slave.rready = 1'b1;
      tick();
      io_slave.rready = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      n_cmp++; if (io_slave.arready !== 1'b1) begin n_bad++; $display("FAIL reset_arready got %b want 1", io_slave.arready); end
      n_cmp++; if (io_slave.awready !== 1'b1) begin n_bad++; $display("FAIL reset_awready got %b want 1", io_slave.awready); end
      n_cmp++; if ({io_slave.wready, io_slave.bvalid, io_slave.rvalid, io_slave.rlast} !== 4'b0)
         begin n_bad++; $display("FAIL reset_valids got %b want 0000", {io_slave.wready, io_slave.bvalid, io_slave.rvalid, io_slave.rlast}); end
      n_cmp++; if (io_slave.rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", io_slave.rdata); end
      n_cmp++; if ({io_slave.rresp, io_slave.bresp, io_slave.rid, io_slave.bid} !== 12'd0)
         begin n_bad++; $display("FAIL reset_resp_ids got %h want 0", {io_slave.rresp, io_slave.bresp, io_slave.rid, io_slave.bid}); end
      reset = 1'b0;
      tick();
      n_cmp++; if (io_slave.arready !== 1'b1 || io_slave.awready !== 1'b1)
         begin n_bad++; $display("FAIL post_reset_ready got %b%b want 11", io_slave.arready, io_slave.awready); end
   endtask

   task automatic test_basic();
      logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int lat;
      axi_write(32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 4'd3, 8'd0, resp, id, lat);
      n_cmp++; if (lat != WR_LAT) begin n_bad++; $display("FAIL wr_latency got %0d want %0d", lat, WR_LAT); end
      n_cmp++; if (resp !== 2'd0) begin n_bad++; $display("FAIL wr_bresp got %0d want 0", resp); end
      n_cmp++; if (id !== 4'd3) begin n_bad++; $display("FAIL wr_bid got %0d want 3", id); end
      axi_read(32'h2000_0010, 4'd5, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (lat != RD_LAT) begin n_bad++; $display("FAIL rd_latency got %0d want %0d", lat, RD_LAT); end
      n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", d); end
      n_cmp++; if (resp !== 2'd0) begin n_bad++; $display("FAIL rd_rresp got %0d want 0", resp); end
      n_cmp++; if (id !== 4'd5) begin n_bad++; $display("FAIL rd_rid got %0d want 5", id); end
      n_cmp++; if (last !== 1'b1) begin n_bad++; $display("FAIL rd_rlast got %b want 1", last); end
   endtask

   task automatic test_strobe();
      logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int lat;
      axi_write(32'h2000_0010, 32'h1122_3344, 4'b0101, 4'd1, 8'd0, resp, id, lat);
      axi_read(32'h2000_0010, 4'd2, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'hDE22_BE44) begin n_bad++; $display("FAIL strobe_merge got %h want de22be44", d); end
      axi_write(32'h2000_0010, 32'hFFFF_FFFF, 4'b0000, 4'd7, 8'd0, resp, id, lat);
      n_cmp++; if (resp !== 2'd0) begin n_bad++; $display("FAIL strobe_zero_bresp got %0d want 0", resp); end
      axi_read(32'h2000_0013, 4'd2, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'hDE22_BE44) begin n_bad++; $display("FAIL strobe_zero_data got %h want de22be44", d); end
   endtask

   task automatic test_errors();
      logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int lat;
      axi_write(32'h2000_0000, 32'h0102_0304, 4'hF, 4'd0, 8'd0, resp, id, lat);
      axi_write(32'h2000_0FFC, 32'hCAFE_F00D, 4'hF, 4'd0, 8'd0, resp, id, lat);
      n_cmp++; if (resp !== 2'd0) begin n_bad++; $display("FAIL last_word_bresp got %0d want 0", resp); end
      axi_read(32'h2000_0FFC, 4'd1, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL last_word_data got %h want cafef00d", d); end
      axi_read(32'h1FFF_FFFC, 4'd4, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (resp !== 2'd2) begin n_bad++; $display("FAIL below_base_rresp got %0d want 2", resp); end
      n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL below_base_rdata got %h want 0", d); end
      axi_write(32'h2000_1000, 32'hBAD0_BAD0, 4'hF, 4'd6, 8'd0, resp, id, lat);
      n_cmp++; if (resp !== 2'd2) begin n_bad++; $display("FAIL above_top_bresp got %0d want 2", resp); end
      n_cmp++; if (id !== 4'd6) begin n_bad++; $display("FAIL above_top_bid got %0d want 6", id); end
      axi_write(32'h2000_0010, 32'hBAD1_BAD1, 4'hF, 4'd6, 8'd2, resp, id, lat);
      n_cmp++; if (resp !== 2'd2) begin n_bad++; $display("FAIL awlen_bresp got %0d want 2", resp); end
      axi_read(32'h2000_0010, 4'd4, 8'd3, d, resp, id, last, lat);
      n_cmp++; if (resp !== 2'd2 || d !== 32'd0) begin n_bad++; $display("FAIL arlen_read got resp %0d data %h want 2 0", resp, d); end
      axi_read(32'h2000_0000, 4'd4, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'h0102_0304) begin n_bad++; $display("FAIL word0_unchanged got %h want 01020304", d); end
      axi_read(32'h2000_0010, 4'd4, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'hDE22_BE44) begin n_bad++; $display("FAIL word4_unchanged got %h want de22be44", d); end
      n_cmp++; if (io_slave.arready !== 1'b1) begin n_bad++; $display("FAIL back_to_back_arready got %b want 1", io_slave.arready); end
   endtask

   task automatic test_stall();
      int guard;
      io_slave.araddr = 32'h2000_0010; io_slave.arid = 4'd9; io_slave.arlen = 8'd0;
      io_slave.arvalid = 1'b1;
      tick();
      io_slave.arvalid = 1'b0;
      guard = 0;
      while (!io_slave.rvalid && guard < 50) begin tick(); guard++; end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (io_slave.rvalid !== 1'b1 || io_slave.rdata !== 32'hDE22_BE44 ||
             io_slave.rid !== 4'd9 || io_slave.arready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold cyc %0d got rvalid %b rdata %h rid %0d arready %b want 1 de22be44 9 0",
                     c, io_slave.rvalid, io_slave.rdata, io_slave.rid, io_slave.arready);
         end
         tick();
      end
      io_slave.rready = 1'b1;
      tick();
      io_slave.rready = 1'b0;
      n_cmp++; if (io_slave.rvalid !== 1'b0 || io_slave.arready !== 1'b1)
         begin n_bad++; $display("FAIL stall_release got rvalid %b arready %b want 0 1", io_slave.rvalid, io_slave.arready); end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int lat;
      io_slave.wdata = 32'h55AA_33CC; io_slave.wstrb = 4'hF; io_slave.wvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (io_slave.wready !== 1'b0) begin n_bad++; $display("FAIL early_w_wready cyc %0d got %b want 0", c, io_slave.wready); end
         tick();
      end
      io_slave.awaddr = 32'h2000_0040; io_slave.awid = 4'd2; io_slave.awlen = 8'd0;
      io_slave.awvalid = 1'b1;
      n_cmp++; if (io_slave.awready !== 1'b1 || io_slave.wready !== 1'b0)
         begin n_bad++; $display("FAIL aw_cycle got awready %b wready %b want 1 0", io_slave.awready, io_slave.wready); end
      tick();
      io_slave.awvalid = 1'b0;
      n_cmp++; if (io_slave.wready !== 1'b1) begin n_bad++; $display("FAIL w_after_aw got %b want 1", io_slave.wready); end
      tick();
      io_slave.wvalid = 1'b0;
      lat = 0;
      while (!io_slave.bvalid && lat < 50) begin tick(); lat++; end
      n_cmp++; if (lat != WR_LAT || io_slave.bresp !== 2'd0)
         begin n_bad++; $display("FAIL early_w_bresp got lat %0d resp %0d want %0d 0", lat, io_slave.bresp, WR_LAT); end
      io_slave.bready = 1'b1;
      tick();
      io_slave.bready = 1'b0;
      axi_read(32'h2000_0040, 4'd1, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'h55AA_33CC) begin n_bad++; $display("FAIL early_w_data got %h want 55aa33cc", d); end
   endtask

   task automatic test_reset_midflight();
      logic [1:0] resp; logic [3:0] id; logic [31:0] d; logic last; int lat;
      axi_write(32'h2000_0020, 32'hAAAA_5555, 4'hF, 4'd0, 8'd0, resp, id, lat);
      io_slave.araddr = 32'h2000_0020; io_slave.arid = 4'd1; io_slave.arlen = 8'd0; io_slave.arvalid = 1'b1;
      io_slave.awaddr = 32'h2000_0020; io_slave.awid = 4'd1; io_slave.awlen = 8'd0; io_slave.awvalid = 1'b1;
      tick();
      io_slave.arvalid = 1'b0; io_slave.awvalid = 1'b0;
      io_slave.wdata = 32'h1234_5678; io_slave.wstrb = 4'hF; io_slave.wvalid = 1'b1;
      tick();
      io_slave.wvalid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (io_slave.arready !== 1'b1 || io_slave.awready !== 1'b1)
         begin n_bad++; $display("FAIL midflight_ready got %b%b want 11", io_slave.arready, io_slave.awready); end
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (io_slave.rvalid !== 1'b0 || io_slave.bvalid !== 1'b0)
            begin n_bad++; $display("FAIL midflight_no_resp cyc %0d got rvalid %b bvalid %b want 0 0", c, io_slave.rvalid, io_slave.bvalid); end
         tick();
      end
      axi_read(32'h2000_0020, 4'd3, 8'd0, d, resp, id, last, lat);
      n_cmp++; if (d !== 32'hAAAA_5555) begin n_bad++; $display("FAIL midflight_word got %h want aaaa5555", d); end
   endtask

   initial begin
      io_slave.awvalid = 1'b0; io_slave.awaddr = '0; io_slave.awid = '0; io_slave.awlen = '0;
      io_slave.wvalid  = 1'b0; io_slave.wdata  = '0; io_slave.wstrb = '0; io_slave.bready = 1'b0;
      io_slave.arvalid = 1'b0; io_slave.araddr = '0; io_slave.arid = '0; io_slave.arlen = '0;
      io_slave.rready  = 1'b0;
      test_reset();
      test_basic();
      test_strobe();
      test_errors();
      test_stall();
      test_w_before_aw();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ysyx_24090012_axi_sram.md
YSYX_24090012_AXI_SRAM -- requirements
Module: ysyx_24090012_axi_sram
Interface
REQ-001 MEM_BASE, 32'h2000_0000, byte address of word 0.
REQ-002 MEM_WORDS, 1024, depth in 32-bit words (power of two).
REQ-003 RD_LAT, 2, cycles from AR handshake to first rvalid (>=1).
REQ-004 WR_LAT, 1, cycles from W data capture to bvalid (>=1).
REQ-005 clock  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 io_slave_awvalid/awready  in/out  1/1  AW handshake.
REQ-008 io_slave_awaddr  in  32  write byte address.
REQ-009 io_slave_awid/awlen  in  4/8  write ID; burst length (only 0 legal).
REQ-010 io_slave_wvalid/wready  in/out  1/1  W handshake.
REQ-011 io_slave_wdata/wstrb  in  32/4  write data; byte-lane enables.
REQ-012 io_slave_bvalid/bready  out/in  1/1  B handshake.
REQ-013 io_slave_bresp/bid  out  2/4  write response (OKAY=0, SLVERR=2); echoed awid.
REQ-014 io_slave_arvalid/arready  in/out  1/1  AR handshake.
REQ-015 io_slave_araddr  in  32  read byte address.
REQ-016 io_slave_arid/arlen  in  4/8  read ID; burst length (only 0 legal).
REQ-017 io_slave_rvalid/rready  out/in  1/1  R handshake.
REQ-018 io_slave_rdata/rresp  out  32/2  read data; read response.
REQ-019 io_slave_rlast/rid  out  1/4  last beat (always 1 with rvalid); echoed arid.
Function
REQ-020 Word index SHALL be (addr - MEM_BASE)[log2(MEM_WORDS)+1:2]; addr[1:0] ignored.
REQ-021 Out-of-range address (addr < MEM_BASE or >= MEM_BASE+4*MEM_WORDS) or len != 0 SHALL yield resp SLVERR, no array write, rdata 0.
REQ-022 Read FSM SHALL be R_IDLE -> R_WAIT -> R_RESP -> R_IDLE; arready=1 only in R_IDLE.
REQ-023 AR handshake SHALL latch araddr/arid/arlen and load latency counter with RD_LAT-1; R_WAIT decrements to 0, then R_RESP.
REQ-024 In R_RESP, rvalid=1, rlast=1, rdata/rresp/rid SHALL stay stable until rready; transition to R_IDLE on rvalid&&rready.
REQ-025 Write FSM SHALL be W_IDLE -> W_DATA -> W_WAIT -> W_RESP -> W_IDLE; awready=1 only in W_IDLE, wready=1 only in W_DATA.
REQ-026 W data arriving before AW SHALL be held off (wready=0) until AW handshake; AW and W never accepted in same cycle.
REQ-027 W handshake SHALL update each byte lane i where wstrb[i]=1 (OKAY case only); wstrb=0 writes nothing, still responds OKAY.
REQ-028 bvalid SHALL assert exactly WR_LAT cycles after W handshake, hold with bresp/bid stable until bready.
REQ-029 Read and write FSMs SHALL be independent and may be active concurrently.
REQ-030 Read of the word written in the same cycle as its array update SHALL return the new data (write-first at array level).
REQ-031 Back-to-back: new AR/AW accepted the cycle after R/B handshake completes (no combinational ready-from-valid path).
REQ-032 Array contents SHALL not be initialised by reset.
Reset
REQ-033 While reset=1: both FSMs to IDLE, counters 0, arready=awready=1, wready=bvalid=rvalid=rlast=0, rdata=0, rresp=bresp=0, rid=bid=0; any in-flight transaction SHALL be discarded without response and without array write.
Configuration
REQ-034 YSYX_24090012_SRAM_RAND_DELAY_EN defined: read and write latencies SHALL be base + lfsr[1:0], 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h5A on reset) advanced once per accepted AR or AW.
REQ-035 Macro undefined: latencies SHALL equal RD_LAT/WR_LAT exactly; no LFSR logic.
Verification
REQ-036 Reset, write 32'hDEADBEEF wstrb=4'hF to 0x2000_0010 id=3 -> bvalid WR_LAT cycles after W, bresp=0, bid=3; read same addr id=5 -> rvalid RD_LAT cycles after AR, rdata=DEADBEEF, rid=5, rlast=1.
REQ-037 Then write 32'h11223344 wstrb=4'b0101 to same addr -> readback 32'hDE22BE44.
REQ-038 Read 0x1FFF_FFFC and write 0x2000_1000 -> rresp=2, rdata=0, bresp=2; arlen=3 read -> rresp=2; array unchanged.
REQ-039 Hold rready=0 for 5 cycles in R_RESP -> rvalid, rdata, rid stable; arready=0 throughout.
REQ-040 Assert wvalid 3 cycles before awvalid -> wready=0 until AW handshake, then data written correctly.
REQ-041 Assert reset during R_WAIT and W_WAIT -> no rvalid/bvalid, next cycle arready=awready=1, target word unchanged.
